cache_axi_arbiter: RTL
======================

// Module: cache_axi_arbiter
// PURPOSE
// Shares one AXI3 master port between icache refill reads, dcache refill/uncached reads and dcache
// writes (write-back or uncached store). Sits between both caches and the AXI interconnect.
// One read and one write transaction may be in flight at a time, independently of each other.
// A dcache read whose line address matches the in-flight write is held off, giving read-after-write ordering.
// PARAMETERS
// LINE_WORDS  4   words per cache line; line burst arlen/awlen = LINE_WORDS-1
// ID_I        0   arid used for icache reads
// ID_D        1   arid/awid used for dcache transactions
// PORTS
// aclk  in 1  clock
// aresetn  in 1  asynchronous active-low reset
// {ic,dc}_rd_req  in 1  read request; rd_type/rd_addr valid while high
// {ic,dc}_rd_type  in 3  000 byte, 001 half, 010 word, 100 line
// {ic,dc}_rd_addr  in 32  read address
// {ic,dc}_rd_rdy  out 1  request accepted this cycle when req&rdy
// {ic,dc}_ret_valid  out 1  returned data beat valid
// {ic,dc}_ret_last  out 1  final beat of the transaction
// {ic,dc}_ret_data  out 32  returned beat (rdata passthrough)
// dc_wr_req  in 1  write request
// dc_wr_type  in 3  encoding as rd_type
// dc_wr_addr  in 32  write address
// dc_wr_wstrb  in 4  byte strobe for non-line writes
// dc_wr_data  in 128  line data; word i in bits [32i+31:32i]
// dc_wr_rdy  out 1  write accepted when wr_req&wr_rdy
// arid/araddr/arlen/arsize/arvalid  out 4/32/8/3/1, arready in 1  AXI read address
// rid/rdata/rlast/rvalid in 4/32/1/1, rready out 1  AXI read data (rresp ignored)
// awid/awaddr/awlen/awsize/awvalid  out 4/32/8/3/1, awready in 1  AXI write address
// wid/wdata/wstrb/wlast/wvalid  out 4/32/4/1/1, wready in 1  AXI write data
// bvalid in 1, bready out 1  AXI write response (bid/bresp ignored)
// BEHAVIOUR
// - Reset, asynchronous: all valids, readies and rdy outputs are 0, both FSMs idle, rr_ptr=0 (icache favoured).
//   aresetn mid-transaction abandons it with no drain.
// - Read FSM R_IDLE -> R_AR -> R_DATA -> R_IDLE.
//   R_IDLE: grant = round-robin. With both requesting, the side not granted last wins.
//   Only the grantee sees rd_rdy=1, combinationally. The grant latches addr/type/id and the FSM moves to R_AR.
// - R_AR: arvalid=1 from the cycle after the grant. arlen = (type==100) ? LINE_WORDS-1 : 0.
//   arsize = (type==100) ? 2 : type[1:0]. Leave on arvalid&arready.
// - R_DATA: rready=1. ret_valid = rvalid to the requester selected by latched id, with ret_last=rlast.
//   On rvalid&rlast, return to R_IDLE and toggle rr_ptr. A new grant is possible the next cycle.
// - RAW hold: dc_rd_rdy=0 while the write FSM is not idle and dc_rd_addr[31:4]==latched awaddr[31:4].
//   Icache is unaffected and may be granted meanwhile.
// - Write FSM W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
//   dc_wr_rdy=1 only in W_IDLE. Acceptance latches addr, type, wstrb and the 128-bit data.
// - W_ADDR: awvalid=1 until awready.
// - W_DATA: wvalid=1. Beat counter bcnt starts at 0 and increments on wready.
//   Line beats: wdata=word[bcnt], wstrb=4'hF. Non-line writes: one beat, wdata=word0, latched wstrb.
//   wlast=(bcnt==awlen). Leave after the last beat handshakes.
// - W_RESP: bready=1, return to W_IDLE on bvalid.
// - Simultaneous read grant and write accept in one cycle are allowed. The RAW check uses the pre-accept
//   write state, so the cache must not issue a same-line read in the same cycle as the write.
// - Outputs hold stable while valid is high and ready is low; AXI stability rules are met.
// TESTING
// 1 Reset: aresetn=0 mid-burst -> all valids/rdy=0 at once; after release ic_rd_req line @0x1c000040
//   -> araddr=0x1c000040, arlen=3, arsize=2, arid=0.
// 2 Arbitration: ic and dc request together on consecutive transactions -> grants go ic, dc, ic, dc.
// 3 Routing: dc line read, 4 rdata beats 0xA0..0xA3 -> dc_ret_valid x4, ret_last on 0xA3, ic_ret_valid stays 0.
// 4 Write line 0x00001230, data {D3,D2,D1,D0}, wready low 2 cycles mid-burst
//   -> beats D0..D3 in order, wstrb=F, wlast on D3, bready until bvalid.
// 5 RAW: write to 0x80 in flight, dc read 0x84 -> dc_rd_rdy=0 until W_IDLE, then granted;
//   dc read 0x100 during the same write -> granted immediately.
// 6 Uncached byte store: type=000, wstrb=0100 -> awlen=0, awsize=0, single beat with wlast=1.

Source files
------------

// File: rtl/cache_axi_arbiter_if.sv
// cache_axi_arbiter_if: cache-side request/return signals plus the shared AXI3 master channels.
interface cache_axi_arbiter_if #(parameter int LINE_WORDS = 4);
  logic                      ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [2:0]                ic_rd_type;
  logic [31:0]               ic_rd_addr, ic_ret_data;
  logic                      dc_rd_req, dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [2:0]                dc_rd_type;
  logic [31:0]               dc_rd_addr, dc_ret_data;
  logic                      dc_wr_req, dc_wr_rdy;
  logic [2:0]                dc_wr_type;
  logic [31:0]               dc_wr_addr;
  logic [3:0]                dc_wr_wstrb;
  logic [32*LINE_WORDS-1:0]  dc_wr_data;
  logic [3:0]                arid, rid, awid, wid, wstrb;
  logic [31:0]               araddr, awaddr, rdata, wdata;
  logic [7:0]                arlen, awlen;
  logic [2:0]                arsize, awsize;
  logic                      arvalid, arready, rlast, rvalid, rready;
  logic                      awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  modport master (
    input  ic_rd_req, ic_rd_type, ic_rd_addr, dc_rd_req, dc_rd_type, dc_rd_addr,
           dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
           arready, rdata, rlast, rvalid, awready, wready, bvalid,
    output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
           dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data, dc_wr_rdy,
           arid, araddr, arlen, arsize, arvalid, rready,
           awid, awaddr, awlen, awsize, awvalid, wid, wdata, wstrb, wlast, wvalid, bready
  );
  modport slave (
    output ic_rd_req, ic_rd_type, ic_rd_addr, dc_rd_req, dc_rd_type, dc_rd_addr,
           dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
           arready, rid, rdata, rlast, rvalid, awready, wready, bvalid,
    input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
           dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data, dc_wr_rdy,
           arid, araddr, arlen, arsize, arvalid, rready,
           awid, awaddr, awlen, awsize, awvalid, wid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI3 master between icache reads, dcache reads and dcache writes.
module cache_axi_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ID_I       = 0,
  parameter int ID_D       = 1
) (
  input logic             aclk,
  input logic             aresetn,
  cache_axi_arbiter_if.master bus
);
  localparam int BW = $clog2(LINE_WORDS);
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  r_state_e                    r_state_q, r_state_d;
  w_state_e                    w_state_q, w_state_d;
  logic                        rr_ptr_q, rr_ptr_d, ar_dc_q, ar_dc_d;
  logic [31:0]                 ar_addr_q, ar_addr_d, w_addr_q, w_addr_d;
  logic [2:0]                  ar_type_q, ar_type_d, w_type_q, w_type_d;
  logic [3:0]                  w_strb_q, w_strb_d;
  logic [LINE_WORDS-1:0][31:0] w_data_q, w_data_d;
  logic [BW-1:0]               bcnt_q, bcnt_d;
  logic raw, gnt_ic, gnt_dc, r_done, w_acc, w_beat, w_last, ar_line, w_line, r_data;
  assign ar_line = ar_type_q == 3'b100;
  assign w_line  = w_type_q == 3'b100;
  assign r_data  = r_state_q == R_DATA;
  assign w_last  = !w_line || bcnt_q == BW'(LINE_WORDS-1);
  always_comb begin
    // the RAW compare sees the write state before any same-cycle accept
    raw       = w_state_q != W_IDLE && bus.dc_rd_addr[31:4] == w_addr_q[31:4];
    gnt_dc    = aresetn && r_state_q == R_IDLE && bus.dc_rd_req && !raw && (!bus.ic_rd_req || rr_ptr_q);
    gnt_ic    = aresetn && r_state_q == R_IDLE && bus.ic_rd_req && !gnt_dc;
    r_done    = r_data && bus.rvalid && bus.rlast;
    r_state_d = gnt_ic || gnt_dc ? R_AR :
                r_state_q == R_AR && bus.arready ? R_DATA : r_done ? R_IDLE : r_state_q;
    ar_addr_d = gnt_dc ? bus.dc_rd_addr : gnt_ic ? bus.ic_rd_addr : ar_addr_q;
    ar_type_d = gnt_dc ? bus.dc_rd_type : gnt_ic ? bus.ic_rd_type : ar_type_q;
    ar_dc_d   = gnt_dc ? 1'b1 : gnt_ic ? 1'b0 : ar_dc_q;
    rr_ptr_d  = r_done ? !ar_dc_q : rr_ptr_q;
    w_acc     = w_state_q == W_IDLE && bus.dc_wr_req;
    w_beat    = w_state_q == W_DATA && bus.wready;
    w_state_d = w_acc ? W_ADDR : w_state_q == W_ADDR && bus.awready ? W_DATA :
                w_beat && w_last ? W_RESP : w_state_q == W_RESP && bus.bvalid ? W_IDLE : w_state_q;
    w_addr_d  = w_acc ? bus.dc_wr_addr : w_addr_q;
    w_type_d  = w_acc ? bus.dc_wr_type : w_type_q;
    w_strb_d  = w_acc ? bus.dc_wr_wstrb : w_strb_q;
    w_data_d  = w_acc ? bus.dc_wr_data : w_data_q;
    bcnt_d    = w_acc ? '0 : w_beat ? bcnt_q + 1'b1 : bcnt_q;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      rr_ptr_q  <= 1'b0;
      ar_dc_q   <= 1'b0;
      ar_addr_q <= '0;
      ar_type_q <= '0;
      w_addr_q  <= '0;
      w_type_q  <= '0;
      w_strb_q  <= '0;
      w_data_q  <= '0;
      bcnt_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      rr_ptr_q  <= rr_ptr_d;
      ar_dc_q   <= ar_dc_d;
      ar_addr_q <= ar_addr_d;
      ar_type_q <= ar_type_d;
      w_addr_q  <= w_addr_d;
      w_type_q  <= w_type_d;
      w_strb_q  <= w_strb_d;
      w_data_q  <= w_data_d;
      bcnt_q    <= bcnt_d;
    end
  end
  assign bus.ic_rd_rdy    = gnt_ic;
  assign bus.dc_rd_rdy    = gnt_dc;
  assign bus.arvalid      = r_state_q == R_AR;
  assign bus.araddr       = ar_addr_q;
  assign bus.arid         = ar_dc_q ? 4'(ID_D) : 4'(ID_I);
  assign bus.arlen        = ar_line ? 8'(LINE_WORDS-1) : 8'd0;
  assign bus.arsize       = ar_line ? 3'd2 : {1'b0, ar_type_q[1:0]};
  assign bus.rready       = r_data;
  assign bus.ic_ret_valid = r_data && bus.rvalid && !ar_dc_q;
  assign bus.dc_ret_valid = r_data && bus.rvalid && ar_dc_q;
  assign bus.ic_ret_last  = bus.ic_ret_valid && bus.rlast;
  assign bus.dc_ret_last  = bus.dc_ret_valid && bus.rlast;
  assign bus.ic_ret_data  = bus.rdata;
  assign bus.dc_ret_data  = bus.rdata;
  assign bus.dc_wr_rdy    = aresetn && w_state_q == W_IDLE;
  assign bus.awvalid      = w_state_q == W_ADDR;
  assign bus.awaddr       = w_addr_q;
  assign bus.awid         = 4'(ID_D);
  assign bus.awlen        = w_line ? 8'(LINE_WORDS-1) : 8'd0;
  assign bus.awsize       = w_line ? 3'd2 : {1'b0, w_type_q[1:0]};
  assign bus.wvalid       = w_state_q == W_DATA;
  assign bus.wid          = 4'(ID_D);
  assign bus.wdata        = w_data_q[w_line ? bcnt_q : '0];
  assign bus.wstrb        = w_line ? 4'hF : w_strb_q;
  assign bus.wlast        = w_last;
  assign bus.bready       = w_state_q == W_RESP;
endmodule
